// File: rtl/conv_arb_pkg.sv
// Shared types and constants for the input/weight SRAM read arbiter.
//   arb_state_e : arbiter FSM states (IDLE, OWN0, OWN1)
//   RID_*       : requester ids carried through the read-tag pipeline
//   DEF_*       : default SRAM geometry
package conv_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic RID_INPUT  = 1'b0;
  localparam logic RID_WEIGHT = 1'b1;

  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned DEF_DATA_W = 16;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-tag pipeline: follows each issued SRAM read through the fixed read
// latency and raises the response valid of the requester that issued it.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset (clears all tags)
//   rd_en, rd_rid    : registered read strobe and its requester id
//   rsp0_valid       : returned word belongs to the input-row fetch
//   rsp1_valid       : returned word belongs to the weight fetch
module rd_tag_pipe
  import conv_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rd_en,
  input  logic rd_rid,
  output logic rsp0_valid,
  output logic rsp1_valid
);

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] rid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      rid_q <= '0;
    end else begin
      vld_q[0] <= rd_en;
      rid_q[0] <= rd_rid;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        rid_q[i] <= rid_q[i-1];
      end
    end
  end

  assign rsp0_valid = vld_q[RD_LAT-1] && (rid_q[RD_LAT-1] == RID_INPUT);
  assign rsp1_valid = vld_q[RD_LAT-1] && (rid_q[RD_LAT-1] == RID_WEIGHT);

endmodule

// File: rtl/sram_rd_arbiter.sv
// Shares the input-SRAM read port between input-row fetch (req0) and weight
// fetch (req1). Whole bursts are granted; the read address is registered and
// returned words are routed back to the requester that issued them.
// Configuration macro: ARB_RR_EN -- round-robin arbitration in IDLE instead of
// fixed priority req1 > req0.
// Ports:
//   clk, reset                   : clock, asynchronous active-high reset
//   reqN_valid/addr/last/ready   : read request handshake (ready is combinational)
//   rspN_valid/data              : returned word for requester N
//   mem_rd_addr, mem_rd_en       : registered SRAM read port
//   mem_rd_data                  : SRAM data, RD_LAT cycles after mem_rd_addr
//   burst_abort                  : one-cycle pulse after a forced release
module sram_rd_arbiter
  import conv_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned BURST_MAX = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req0_last,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              burst_abort
);

  localparam int unsigned CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  arb_state_e       state_q;
  logic [CNT_W-1:0] beat_cnt_q;
  logic             rid_q;
`ifdef ARB_RR_EN
  // 1: req0 wins the next IDLE tie; reset value keeps req1 first.
  logic             rr_q;
`endif

  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              acc_rid;
  logic              acc_last;
  logic [ADDR_W-1:0] acc_addr;
  logic              force_rel;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    unique case (state_q)
      IDLE: begin
`ifdef ARB_RR_EN
        if (req0_valid && req1_valid) begin
          grant0 = rr_q;
          grant1 = !rr_q;
        end else begin
          grant0 = req0_valid;
          grant1 = req1_valid;
        end
`else
        grant1 = req1_valid;
        grant0 = req0_valid && !req1_valid;
`endif
      end
      OWN0:    grant0 = req0_valid;
      OWN1:    grant1 = req1_valid;
      default: ;
    endcase
    // No handshake may complete while the block is held in reset.
    if (reset) begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;
  assign acc_rid    = grant1 ? RID_WEIGHT : RID_INPUT;
  assign acc_last   = grant1 ? req1_last : req0_last;
  assign acc_addr   = grant1 ? req1_addr : req0_addr;
  // This accept would be beat BURST_MAX of the burst without ending it.
  assign force_rel  = accept && !acc_last && (beat_cnt_q == CNT_W'(BURST_MAX - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      rid_q       <= RID_INPUT;
      mem_rd_addr <= '0;
      mem_rd_en   <= 1'b0;
      burst_abort <= 1'b0;
`ifdef ARB_RR_EN
      rr_q        <= 1'b0;
`endif
    end else begin
      mem_rd_en   <= accept;
      burst_abort <= force_rel;
      if (accept) begin
        mem_rd_addr <= acc_addr;
        rid_q       <= acc_rid;
        if (acc_last || force_rel) begin
          state_q    <= IDLE;
          beat_cnt_q <= '0;
`ifdef ARB_RR_EN
          // Favour whoever did not own this burst.
          rr_q       <= (acc_rid == RID_WEIGHT);
`endif
        end else begin
          state_q    <= (acc_rid == RID_WEIGHT) ? OWN1 : OWN0;
          beat_cnt_q <= beat_cnt_q + 1'b1;
        end
      end
    end
  end

  rd_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_rd_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .rd_en     (mem_rd_en),
    .rd_rid    (rid_q),
    .rsp0_valid(rsp0_valid),
    .rsp1_valid(rsp1_valid)
  );

  assign rsp0_data = mem_rd_data;
  assign rsp1_data = mem_rd_data;

endmodule

// File: tb/tb_sram_rd_arbiter.sv
// Bench for sram_rd_arbiter: burst-level reference model of the arbitration
// rules, an SRAM model with fixed read latency, and an in-order response
// scoreboard checked by an independent monitor.
module tb_sram_rd_arbiter;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 16;
  localparam int RD_LAT    = 2;
  localparam int BURST_MAX = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req0_valid = 1'b0, req1_valid = 1'b0;
  logic [ADDR_W-1:0] req0_addr = '0, req1_addr = '0;
  logic              req0_last = 1'b0, req1_last = 1'b0;
  logic              req0_ready, req1_ready;
  logic              rsp0_valid, rsp1_valid;
  logic [DATA_W-1:0] rsp0_data, rsp1_data;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rd_data;
  logic              burst_abort;

  sram_rd_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_last(req0_last),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_last(req1_last),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .mem_rd_addr(mem_rd_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .burst_abort(burst_abort)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] memf(input logic [ADDR_W-1:0] a);
    return {a[3:0], a} ^ 16'h5A3C;
  endfunction

  // SRAM: word for the address registered at edge T is presented after edge T+RD_LAT.
  logic [DATA_W-1:0] sram_pipe [RD_LAT];
  always @(posedge clk) begin
    for (int i = RD_LAT - 1; i > 0; i--) sram_pipe[i] <= sram_pipe[i-1];
    sram_pipe[0] <= memf(mem_rd_addr);
  end
  assign mem_rd_data = sram_pipe[RD_LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int                rid;
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;
  exp_t sb[$];

  // Reference model state (burst-level view of the arbitration rules).
  int                m_owner = -1;   // -1: nobody owns the port
  int                m_beats = 0;    // beats accepted in the current burst
  bit                m_pref0 = 1'b0; // round-robin: req0 wins the next tie
  logic              exp_en = 1'b0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic              exp_abort = 1'b0;
  bit                acc_m [2];
  int                win;
  logic              mv [2];
  logic [ADDR_W-1:0] ma [2];
  logic              ml [2];

  always @(negedge clk) begin
    if (reset) begin
      m_owner = -1; m_beats = 0; m_pref0 = 1'b0;
      exp_en = 1'b0; exp_addr = '0; exp_abort = 1'b0;
      acc_m[0] = 1'b0; acc_m[1] = 1'b0;
      sb.delete();
    end else begin
      chk("mem_rd_en", mem_rd_en, exp_en);
      chk("mem_rd_addr", mem_rd_addr, exp_addr);
      chk("burst_abort", burst_abort, exp_abort);
      mv[0] = req0_valid; ma[0] = req0_addr; ml[0] = req0_last;
      mv[1] = req1_valid; ma[1] = req1_addr; ml[1] = req1_last;
      win = -1;
      if (m_owner == -1) begin
        if (mv[0] && mv[1]) begin
`ifdef ARB_RR_EN
          win = m_pref0 ? 0 : 1;
`else
          win = 1;
`endif
        end else if (mv[1]) win = 1;
        else if (mv[0]) win = 0;
      end else if (mv[m_owner]) begin
        win = m_owner;
      end
      chk("req0_ready", req0_ready, (win == 0));
      chk("req1_ready", req1_ready, (win == 1));
      acc_m[0] = (win == 0);
      acc_m[1] = (win == 1);
      exp_en = (win >= 0);
      exp_abort = 1'b0;
      if (win >= 0) begin
        exp_addr = ma[win];
        sb.push_back('{rid: win, data: memf(ma[win]), due: cyc + RD_LAT + 1});
        m_beats++;
        if (ml[win] || m_beats == BURST_MAX) begin
          exp_abort = !ml[win];
          m_owner = -1;
          m_beats = 0;
          m_pref0 = (win == 1);
        end else begin
          m_owner = win;
        end
      end
    end
  end

  // Response monitor.
  int   abort_seen = 0;
  int   rsp_seen = 0;
  exp_t e;
  always @(negedge clk) begin
    if (!reset) begin
      if (burst_abort) abort_seen++;
      if (rsp0_valid || rsp1_valid) begin
        rsp_seen++;
        chk("rsp_onehot", rsp0_valid & rsp1_valid, 1'b0);
        if (sb.size() == 0) begin
          chk("rsp_unexpected_pending", 0, 1);
        end else begin
          e = sb.pop_front();
          chk("rsp_rid", rsp1_valid ? 1 : 0, e.rid);
          chk("rsp_data", rsp1_valid ? rsp1_data : rsp0_data, e.data);
          chk("rsp_cycle", cyc, e.due);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("rsp_missing_valid", 0, 1);
      end
    end
  end

  // Requester sources.
  int b_len [2], b_idx [2], b_base [2], gap_pct [2];
  bit b_nolast [2], b_act [2], hold [2];
  int auto_mode = 0; // 0 off, 1 random bursts, 2 back-to-back single beats

  task automatic start_burst(input int r, input int base, input int len,
                             input bit nolast, input int gap);
    b_base[r] = base; b_len[r] = len; b_idx[r] = 0;
    b_nolast[r] = nolast; gap_pct[r] = gap; b_act[r] = 1'b1;
  endtask

  task automatic apply_inputs();
    logic v [2];
    logic [ADDR_W-1:0] a [2];
    logic l [2];
    for (int r = 0; r < 2; r++) begin
      v[r] = b_act[r] && !hold[r] && ($urandom_range(99) >= gap_pct[r]);
      a[r] = ADDR_W'(b_base[r] + b_idx[r]);
      l[r] = !b_nolast[r] && (b_idx[r] == b_len[r] - 1);
    end
    req0_valid = v[0]; req0_addr = a[0]; req0_last = l[0];
    req1_valid = v[1]; req1_addr = a[1]; req1_last = l[1];
  endtask

  task automatic cyc_step();
    @(posedge clk);
    #1;
    for (int r = 0; r < 2; r++) begin
      if (acc_m[r]) begin
        b_idx[r]++;
        if (b_idx[r] >= b_len[r]) b_act[r] = 1'b0;
      end
    end
    for (int r = 0; r < 2; r++) begin
      if (!b_act[r]) begin
        if (auto_mode == 2) start_burst(r, 16 * r + 12'h600, 1, 1'b0, 0);
        else if (auto_mode == 1 && $urandom_range(3) == 0)
          start_burst(r, int'($urandom_range(4095)), int'($urandom_range(8, 1)), 1'b0, 20);
      end
    end
    apply_inputs();
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((b_act[0] || b_act[1] || sb.size() != 0) && n < max) begin
      cyc_step();
      n++;
    end
    chk("idle_within_bound", (b_act[0] || b_act[1] || sb.size() != 0), 0);
  endtask

  int a0, r0, n;

  initial begin
    for (int r = 0; r < 2; r++) begin
      b_act[r] = 1'b0; hold[r] = 1'b0; acc_m[r] = 1'b0;
      b_len[r] = 0; b_idx[r] = 0; b_base[r] = 0; gap_pct[r] = 0; b_nolast[r] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_mem_rd_addr", mem_rd_addr, 0);
    chk("rst_burst_abort", burst_abort, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    reset = 1'b0;

    // Single read.
    start_burst(0, 12'h005, 1, 1'b0, 0);
    apply_inputs();
    wait_idle(20);

    // Contention: req1 burst must complete before req0 starts.
    start_burst(1, 12'h100, 4, 1'b0, 0);
    start_burst(0, 12'h200, 4, 1'b0, 0);
    apply_inputs();
    wait_idle(40);

    // Lock hold: owner drops valid for 3 cycles while req0 waits.
    start_burst(1, 12'h300, 6, 1'b0, 0);
    start_burst(0, 12'h400, 2, 1'b0, 0);
    apply_inputs();
    n = 0;
    while (b_idx[1] < 2 && n < 20) begin cyc_step(); n++; end
    chk("lock_burst_started", (b_idx[1] >= 2), 1);
    hold[1] = 1'b1;
    apply_inputs();
    repeat (3) cyc_step();
    hold[1] = 1'b0;
    apply_inputs();
    wait_idle(40);

    // Forced release after BURST_MAX beats without last.
    a0 = abort_seen;
    start_burst(0, 12'h800, 70, 1'b1, 0);
    apply_inputs();
    wait_idle(200);
    chk("abort_pulses", abort_seen - a0, 1);

    // Both requesters always valid with single-beat bursts.
    auto_mode = 2;
    repeat (8) cyc_step();
    auto_mode = 0;
    wait_idle(40);

    // Random traffic.
    auto_mode = 1;
    repeat (400) cyc_step();
    auto_mode = 0;
    wait_idle(400);

    // Reset with two reads in flight.
    start_burst(0, 12'hA00, 8, 1'b0, 0);
    apply_inputs();
    n = 0;
    while (b_idx[0] < 2 && n < 20) begin cyc_step(); n++; end
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_mem_rd_en", mem_rd_en, 0);
    chk("mid_rst_mem_rd_addr", mem_rd_addr, 0);
    chk("mid_rst_rsp0_valid", rsp0_valid, 0);
    chk("mid_rst_rsp1_valid", rsp1_valid, 0);
    chk("mid_rst_burst_abort", burst_abort, 0);
    chk("mid_rst_req0_ready", req0_ready, 0);
    b_act[0] = 1'b0; b_act[1] = 1'b0;
    apply_inputs();
    r0 = rsp_seen;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (8) cyc_step();
    chk("rsp_after_reset", rsp_seen - r0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
